// File: rtl/frame_grabber_if.sv
// Video-in and framebuffer-write bundle for frame_grabber.
// The harness drives the master side and the grabber implements the slave side.
interface frame_grabber_if #(
  parameter int RGB_W  = 24,
  parameter int ADDR_W = 15
);
  logic              hsync;
  logic              vsync;
  logic [RGB_W-1:0]  rgb;
  logic              arm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_data;
  logic              busy;
  logic              frame_done;
  logic              err;

  modport master (
    output hsync, vsync, rgb, arm,
    input  wr_en, wr_addr, wr_data, busy, frame_done, err
  );

  modport slave (
    input  hsync, vsync, rgb, arm,
    output wr_en, wr_addr, wr_data, busy, frame_done, err
  );
endinterface

// File: rtl/frame_grabber.sv
// Captures one armed video frame from hsync/vsync/rgb into a linear framebuffer.
// Pixel positions are recovered from sync trailing edges and a fixed pixel divider.
module frame_grabber #(
  parameter int ACTIVE_W = 256,
  parameter int ACTIVE_H = 128,
  parameter int H_START  = 48,
  parameter int V_START  = 33,
  parameter int PIX_DIV  = 4,
  parameter int RGB_W    = 24,
  parameter int ADDR_W   = 15
) (
  input logic            clk,
  input logic            reset,
  frame_grabber_if.slave fg_io
);

  localparam int HSKIP_CYC = H_START * PIX_DIV;
  localparam int DLY_W  = (HSKIP_CYC > 1) ? $clog2(HSKIP_CYC) : 1;
  localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int PIX_W  = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
  localparam int LINE_W = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
  localparam int VC_W   = (V_START > 1) ? $clog2(V_START) : 1;

  // HSKIP lasts exactly HSKIP_CYC cycles, so the counter runs from HSKIP_CYC-1 down to 0.
  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'((HSKIP_CYC > 0) ? HSKIP_CYC - 1 : 0);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PIX_DIV - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(ACTIVE_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ACTIVE_H - 1);
  localparam logic [VC_W-1:0]   V_LAST    = VC_W'((V_START > 0) ? V_START - 1 : 0);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(ACTIVE_W);

  typedef enum logic [2:0] {
    IDLE, WAIT_VS, VSKIP, HSKIP, CAPTURE, WAIT_HS, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              hsReg_q, hsPrev_q, vsReg_q, vsPrev_q;
  logic [RGB_W-1:0]  rgbReg_q;
  logic [VC_W-1:0]   vCnt_q, vCnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] lineBase_q, lineBase_d;
  logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [RGB_W-1:0]  wrData_q, wrData_d;
  logic              busy_q, busy_d;
  logic              frameDone_q, frameDone_d;
  logic              err_q, err_d;
  logic              hsFall, vsFall;

  assign hsFall = hsPrev_q & ~hsReg_q;
  assign vsFall = vsPrev_q & ~vsReg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hsReg_q     <= 1'b0;
      hsPrev_q    <= 1'b0;
      vsReg_q     <= 1'b0;
      vsPrev_q    <= 1'b0;
      rgbReg_q    <= '0;
      vCnt_q      <= '0;
      dly_q       <= '0;
      div_q       <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      lineBase_q  <= '0;
      addrCnt_q   <= '0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsReg_q     <= fg_io.hsync;
      hsPrev_q    <= hsReg_q;
      vsReg_q     <= fg_io.vsync;
      vsPrev_q    <= vsReg_q;
      rgbReg_q    <= fg_io.rgb;
      vCnt_q      <= vCnt_d;
      dly_q       <= dly_d;
      div_q       <= div_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      lineBase_q  <= lineBase_d;
      addrCnt_q   <= addrCnt_d;
      wrEn_q      <= wrEn_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
      err_q       <= err_d;
    end
  end

  // A vsync trailing edge outranks an hsync edge in the same cycle in every active state.
  always_comb begin
    state_d     = state_q;
    vCnt_d      = vCnt_q;
    dly_d       = dly_q;
    div_d       = div_q;
    pix_d       = pix_q;
    line_d      = line_q;
    lineBase_d  = lineBase_q;
    addrCnt_d   = addrCnt_q;
    wrEn_d      = 1'b0;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    busy_d      = busy_q;
    frameDone_d = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (fg_io.arm) begin
          state_d   = WAIT_VS;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          addrCnt_d = '0;
        end
      end
      WAIT_VS: begin
        if (vsFall) begin
          state_d = VSKIP;
          vCnt_d  = '0;
        end
      end
      VSKIP: begin
        if (vsFall) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (hsFall) begin
          if (vCnt_q >= V_LAST) begin
            state_d    = HSKIP;
            line_d     = '0;
            lineBase_d = '0;
            dly_d      = DLY_LOAD;
          end else begin
            vCnt_d = vCnt_q + 1'b1;
          end
        end
      end
      HSKIP: begin
        if (vsFall) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (dly_q == '0) begin
          state_d = CAPTURE;
          div_d   = '0;
          pix_d   = '0;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      CAPTURE: begin
        if (vsFall) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (hsFall) begin
          // Short line: skip the unwritten addresses and reuse this edge as the next line's start.
          err_d      = 1'b1;
          addrCnt_d  = lineBase_q + LINE_STEP;
          lineBase_d = lineBase_q + LINE_STEP;
          if (line_q == LINE_LAST) begin
            state_d = DONE;
          end else begin
            line_d  = line_q + 1'b1;
            dly_d   = DLY_LOAD;
            state_d = HSKIP;
          end
        end else if (div_q == '0) begin
          wrEn_d    = 1'b1;
          wrAddr_d  = addrCnt_q;
          wrData_d  = rgbReg_q;
          addrCnt_d = addrCnt_q + 1'b1;
          div_d     = DIV_LAST;
          if (pix_q == PIX_LAST) begin
            lineBase_d = lineBase_q + LINE_STEP;
            if (line_q == LINE_LAST) begin
              state_d = DONE;
            end else begin
              line_d  = line_q + 1'b1;
              state_d = WAIT_HS;
            end
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      WAIT_HS: begin
        if (vsFall) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (hsFall) begin
          dly_d   = DLY_LOAD;
          state_d = HSKIP;
        end
      end
      DONE: begin
        frameDone_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fg_io.wr_en      = wrEn_q;
  assign fg_io.wr_addr    = wrAddr_q;
  assign fg_io.wr_data    = wrData_q;
  assign fg_io.busy       = busy_q;
  assign fg_io.frame_done = frameDone_q;
  assign fg_io.err        = err_q;

endmodule

// File: tb/tb_frame_grabber.sv
// Directed bench for frame_grabber on a small synthetic raster (8x4 active, rgb = 16*line+column).
module tb_frame_grabber;

  localparam int AW  = 8;
  localparam int AH  = 4;
  localparam int HS  = 2;
  localparam int VS  = 1;
  localparam int PD  = 4;
  localparam int RW  = 24;
  localparam int ADW = 15;
  localparam logic [RW-1:0] BLANK = 24'hA5A5A5;

  logic clk;
  logic reset;

  frame_grabber_if #(.RGB_W(RW), .ADDR_W(ADW)) fgBus ();

  frame_grabber #(
    .ACTIVE_W(AW), .ACTIVE_H(AH), .H_START(HS), .V_START(VS),
    .PIX_DIV(PD), .RGB_W(RW), .ADDR_W(ADW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fg_io (fgBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write/event log, sampled on the falling edge away from DUT updates.
  logic [ADW-1:0] wrAddrQ[$];
  logic [RW-1:0]  wrDataQ[$];
  int  cycle = 0;
  int  lastWrCycle = 0;
  int  fdCycle = 0;
  int  fdCount = 0;
  int  busyHigh = 0;
  int  dblWr = 0;
  bit  busyAtDone = 1'b0;
  bit  prevWrEn = 1'b0;

  always @(negedge clk) begin
    cycle++;
    if (fgBus.wr_en) begin
      wrAddrQ.push_back(fgBus.wr_addr);
      wrDataQ.push_back(fgBus.wr_data);
      lastWrCycle = cycle;
      if (prevWrEn) dblWr++;
    end
    prevWrEn = fgBus.wr_en;
    if (fgBus.frame_done) begin
      fdCount++;
      fdCycle = cycle;
      busyAtDone = fgBus.busy;
    end
    if (fgBus.busy) busyHigh++;
  end

  task automatic clear_log();
    wrAddrQ.delete();
    wrDataQ.delete();
    fdCount  = 0;
    busyHigh = 0;
    dblWr    = 0;
  endtask

  function automatic logic [RW-1:0] exp_data(input int addr);
    return RW'(16 * (addr / AW) + (addr % AW));
  endfunction

  task automatic applyStimulus(input logic h, input logic v, input logic [RW-1:0] d, input int n);
    fgBus.hsync = h;
    fgBus.vsync = v;
    fgBus.rgb   = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    fgBus.arm = 1'b1;
    @(posedge clk);
    #1;
    fgBus.arm = 1'b0;
  endtask

  // One frame: vsync pulse, then AH active lines plus one trailing line.
  // cutLine ends after 5 pixels with a one-cycle hsync that starts the next line.
  task automatic drive_frame(input int armLine, input int cutLine, input int stopLine);
    applyStimulus(1'b0, 1'b1, BLANK, 2 * PD);
    applyStimulus(1'b0, 1'b0, BLANK, PD);
    for (int ln = 0; ln <= AH; ln++) begin
      int npix;
      npix = (ln == cutLine) ? 5 : AW;
      if (!(cutLine >= 0 && ln == cutLine + 1)) applyStimulus(1'b1, 1'b0, BLANK, 2 * PD);
      applyStimulus(1'b0, 1'b0, BLANK, HS * PD);
      for (int c = 0; c < npix; c++) begin
        logic [RW-1:0] px;
        px = RW'(16 * ln + c);
        if (ln == stopLine && c == 3) return;
        if (ln == armLine && c == 2) begin
          fgBus.arm = 1'b1;
          applyStimulus(1'b0, 1'b0, px, 1);
          fgBus.arm = 1'b0;
          applyStimulus(1'b0, 1'b0, px, PD - 1);
        end else begin
          applyStimulus(1'b0, 1'b0, px, PD);
        end
      end
      if (ln == cutLine) applyStimulus(1'b1, 1'b0, BLANK, 1);
      else applyStimulus(1'b0, 1'b0, BLANK, 3 * PD);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fgBus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", fgBus.wr_en); end
    checks++; if (fgBus.wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", fgBus.wr_addr); end
    checks++; if (fgBus.wr_data !== '0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", fgBus.wr_data); end
    checks++; if (fgBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", fgBus.busy); end
    checks++; if (fgBus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", fgBus.frame_done); end
    checks++; if (fgBus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", fgBus.err); end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, BLANK, 2);
  endtask

  task automatic test_no_arm();
    clear_log();
    for (int f = 0; f < 3; f++) drive_frame(-1, -1, -1);
    checks++; if (wrAddrQ.size() != 0) begin errors++; $display("[TB] FAIL noarm_writes: got %0d expected 0", wrAddrQ.size()); end
    checks++; if (busyHigh != 0) begin errors++; $display("[TB] FAIL noarm_busy_cycles: got %0d expected 0", busyHigh); end
    checks++; if (fdCount != 0) begin errors++; $display("[TB] FAIL noarm_frame_done: got %0d expected 0", fdCount); end
  endtask

  task automatic test_capture();
    clear_log();
    pulse_arm();
    checks++; if (fgBus.busy !== 1'b1) begin errors++; $display("[TB] FAIL capture_busy_rise: got %b expected 1", fgBus.busy); end
    drive_frame(-1, -1, -1);
    applyStimulus(1'b0, 1'b0, BLANK, 2 * PD);
    checks++; if (wrAddrQ.size() != AW * AH) begin errors++; $display("[TB] FAIL capture_count: got %0d expected %0d", wrAddrQ.size(), AW * AH); end
    for (int i = 0; i < wrAddrQ.size() && i < AW * AH; i++) begin
      checks++;
      if (wrAddrQ[i] !== ADW'(i) || wrDataQ[i] !== exp_data(i)) begin
        errors++;
        $display("[TB] FAIL capture_write[%0d]: got addr %0d data %h expected addr %0d data %h", i, wrAddrQ[i], wrDataQ[i], i, exp_data(i));
      end
    end
    checks++; if (dblWr != 0) begin errors++; $display("[TB] FAIL capture_single_strobe: got %0d back-to-back strobes expected 0", dblWr); end
    checks++; if (fdCount != 1) begin errors++; $display("[TB] FAIL capture_frame_done_count: got %0d expected 1", fdCount); end
    checks++; if (fdCycle != lastWrCycle + 1) begin errors++; $display("[TB] FAIL capture_done_timing: got cycle %0d expected %0d", fdCycle, lastWrCycle + 1); end
    checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL capture_busy_at_done: got %b expected 0", busyAtDone); end
    checks++; if (fgBus.err !== 1'b0) begin errors++; $display("[TB] FAIL capture_err: got %b expected 0", fgBus.err); end
    checks++; if (fgBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL capture_busy_end: got %b expected 0", fgBus.busy); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_arm();
    drive_frame(1, -1, -1);
    applyStimulus(1'b0, 1'b0, BLANK, 2 * PD);
    checks++; if (wrAddrQ.size() != AW * AH) begin errors++; $display("[TB] FAIL rearm_count: got %0d expected %0d", wrAddrQ.size(), AW * AH); end
    for (int i = 0; i < wrAddrQ.size() && i < AW * AH; i++) begin
      checks++;
      if (wrAddrQ[i] !== ADW'(i) || wrDataQ[i] !== exp_data(i)) begin
        errors++;
        $display("[TB] FAIL rearm_write[%0d]: got addr %0d data %h expected addr %0d data %h", i, wrAddrQ[i], wrDataQ[i], i, exp_data(i));
      end
    end
    checks++; if (fdCount != 1) begin errors++; $display("[TB] FAIL rearm_frame_done_count: got %0d expected 1", fdCount); end
    checks++; if (fgBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rearm_busy_end: got %b expected 0", fgBus.busy); end
  endtask

  task automatic test_short_line();
    int expAddr;
    clear_log();
    pulse_arm();
    drive_frame(3, 2, -1);
    applyStimulus(1'b0, 1'b0, BLANK, 2 * PD);
    checks++; if (wrAddrQ.size() != AW * AH - 3) begin errors++; $display("[TB] FAIL shortline_count: got %0d expected %0d", wrAddrQ.size(), AW * AH - 3); end
    for (int i = 0; i < wrAddrQ.size() && i < AW * AH - 3; i++) begin
      expAddr = (i < 2 * AW + 5) ? i : i + 3;
      checks++;
      if (wrAddrQ[i] !== ADW'(expAddr) || wrDataQ[i] !== exp_data(expAddr)) begin
        errors++;
        $display("[TB] FAIL shortline_write[%0d]: got addr %0d data %h expected addr %0d data %h", i, wrAddrQ[i], wrDataQ[i], expAddr, exp_data(expAddr));
      end
    end
    checks++; if (fgBus.err !== 1'b1) begin errors++; $display("[TB] FAIL shortline_err: got %b expected 1", fgBus.err); end
    checks++; if (fdCount != 1) begin errors++; $display("[TB] FAIL shortline_frame_done: got %0d expected 1", fdCount); end
  endtask

  task automatic test_short_frame();
    int n0;
    clear_log();
    pulse_arm();
    checks++; if (fgBus.err !== 1'b0) begin errors++; $display("[TB] FAIL shortframe_arm_clears_err: got %b expected 0", fgBus.err); end
    drive_frame(-1, -1, 1);
    applyStimulus(1'b0, 1'b1, BLANK, PD);
    applyStimulus(1'b0, 1'b0, BLANK, PD);
    checks++; if (fgBus.err !== 1'b1) begin errors++; $display("[TB] FAIL shortframe_err: got %b expected 1", fgBus.err); end
    checks++; if (fgBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL shortframe_busy: got %b expected 0", fgBus.busy); end
    n0 = wrAddrQ.size();
    applyStimulus(1'b0, 1'b0, BLANK, 6 * PD);
    checks++; if (wrAddrQ.size() != n0) begin errors++; $display("[TB] FAIL shortframe_no_writes: got %0d expected %0d", wrAddrQ.size(), n0); end
    checks++; if (fdCount != 0) begin errors++; $display("[TB] FAIL shortframe_frame_done: got %0d expected 0", fdCount); end
    pulse_arm();
    checks++; if (fgBus.err !== 1'b0) begin errors++; $display("[TB] FAIL shortframe_rearm_err: got %b expected 0", fgBus.err); end
    clear_log();
    drive_frame(-1, -1, -1);
    applyStimulus(1'b0, 1'b0, BLANK, 2 * PD);
    checks++; if (wrAddrQ.size() != AW * AH) begin errors++; $display("[TB] FAIL recover_count: got %0d expected %0d", wrAddrQ.size(), AW * AH); end
    for (int i = 0; i < wrAddrQ.size() && i < AW * AH; i++) begin
      checks++;
      if (wrAddrQ[i] !== ADW'(i) || wrDataQ[i] !== exp_data(i)) begin
        errors++;
        $display("[TB] FAIL recover_write[%0d]: got addr %0d data %h expected addr %0d data %h", i, wrAddrQ[i], wrDataQ[i], i, exp_data(i));
      end
    end
    checks++; if (fgBus.err !== 1'b0) begin errors++; $display("[TB] FAIL recover_err: got %b expected 0", fgBus.err); end
    checks++; if (fdCount != 1) begin errors++; $display("[TB] FAIL recover_frame_done: got %0d expected 1", fdCount); end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_log();
    pulse_arm();
    drive_frame(-1, -1, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (fgBus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_wr_en: got %b expected 0", fgBus.wr_en); end
    checks++; if (fgBus.wr_addr !== '0) begin errors++; $display("[TB] FAIL midreset_wr_addr: got %0d expected 0", fgBus.wr_addr); end
    checks++; if (fgBus.wr_data !== '0) begin errors++; $display("[TB] FAIL midreset_wr_data: got %h expected 0", fgBus.wr_data); end
    checks++; if (fgBus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", fgBus.busy); end
    checks++; if (fgBus.err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err: got %b expected 0", fgBus.err); end
    n0 = wrAddrQ.size();
    applyStimulus(1'b0, 1'b0, RW'(16 + 3), 5 * PD);
    applyStimulus(1'b0, 1'b0, BLANK, 3 * PD);
    applyStimulus(1'b1, 1'b0, BLANK, 2 * PD);
    applyStimulus(1'b0, 1'b0, BLANK, 12 * PD);
    checks++; if (wrAddrQ.size() != n0) begin errors++; $display("[TB] FAIL midreset_no_writes: got %0d expected %0d", wrAddrQ.size(), n0); end
    checks++; if (fdCount != 0) begin errors++; $display("[TB] FAIL midreset_frame_done: got %0d expected 0", fdCount); end
  endtask

  initial begin
    reset       = 1'b1;
    fgBus.hsync = 1'b0;
    fgBus.vsync = 1'b0;
    fgBus.rgb   = '0;
    fgBus.arm   = 1'b0;
    test_reset();
    test_no_arm();
    test_capture();
    test_back_to_back();
    test_short_line();
    test_short_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
